// File: rtl/fanout_settle_pkg.sv
// fanout_settle_pkg
//   Shared definitions for the fan-out settle checker.
//   st_e      : FSM state encoding
//   popcount  : bit count over a vector zero-extended to POP_MAX_W bits
//   SAT_MAX   : largest value held by an unsigned counter of a given width
package fanout_settle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } st_e;

  // Callers zero-extend their vector to this width, so channel counts up to
  // POP_MAX_W share one function.
  localparam int POP_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  // Valid for widths 1..63.
  function automatic logic [63:0] SAT_MAX(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/fanout_settle_compare.sv
// fanout_settle_compare
//   Combinational per-channel check of the observed copies against the
//   current source bit.
//   chan_in   in  : observed channel values (4-state)
//   src       in  : source bit currently driven
//   inv_q     in  : per-channel invert flags (1 = channel is an inverted copy)
//   bad_known out : channel is known but differs from its expected value
//   bad_x     out : channel is X or Z
//   bad_cnt   out : number of bad channels (known-wrong plus unknown)
module fanout_settle_compare
  import fanout_settle_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CNT_BITS = $clog2(CHANNELS + 1)
) (
  input  logic [CHANNELS-1:0] chan_in,
  input  logic                src,
  input  logic [CHANNELS-1:0] inv_q,
  output logic [CHANNELS-1:0] bad_known,
  output logic [CHANNELS-1:0] bad_x,
  output logic [CNT_BITS-1:0] bad_cnt
);

  logic [POP_MAX_W-1:0] bad_ext;

  always_comb begin
    bad_known = '0;
    bad_x     = '0;
    bad_ext   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bad_x[i] = $isunknown(chan_in[i]);
      // Gate with !bad_x so an unknown sample never also lands in bad_known.
      bad_known[i] = !bad_x[i] && (chan_in[i] != (src ^ inv_q[i]));
    end
    bad_ext[CHANNELS-1:0] = bad_known | bad_x;
    bad_cnt = CNT_BITS'(popcount(bad_ext));
  end

endmodule

// File: rtl/fanout_settle_checker.sv
// fanout_settle_checker
//   Drives one source bit through an alternating sequence and checks CHANNELS
//   buffered/inverted copies of it after a settle window.
//   clk, rst     in  : clock, asynchronous active-high reset
//   start        in  : run request, accepted only in IDLE
//   init_val     in  : first source value of the run
//   invert_mask  in  : per-channel invert flags
//   chan_in      in  : observed channel copies
//   src          out : driven source bit
//   busy         out : run in progress (DRIVE/WAIT/CHECK)
//   done         out : one-cycle end-of-run pulse
//   pass         out : no wrong or unknown samples (valid while done)
//   fail_mask    out : sticky known-wrong flags
//   x_mask       out : sticky X/Z flags
//   err_count    out : saturating count of bad samples
//
// state | meaning
// IDLE  | waiting for start; results held
// DRIVE | put step_val on src
// WAIT  | settle window of SETTLE_CYCLES cycles
// CHECK | sample chan_in, accumulate errors, advance step
// DONE  | done pulse, pass valid
module fanout_settle_checker
  import fanout_settle_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_STEPS     = 4,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                init_val,
  input  logic [CHANNELS-1:0] invert_mask,
  input  logic [CHANNELS-1:0] chan_in,
  output logic                src,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CHANNELS-1:0] fail_mask,
  output logic [CHANNELS-1:0] x_mask,
  output logic [CNT_W-1:0]    err_count
);

  localparam int BC_W   = $clog2(CHANNELS + 1);
  localparam int SUM_W  = ((CNT_W > BC_W) ? CNT_W : BC_W) + 1;
  localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SAT_MAX(CNT_W));
  localparam logic [WAIT_W-1:0] WAIT_LAST = (SETTLE_CYCLES > 0) ? WAIT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  st_e                 state;
  logic                step_val;
  logic [CHANNELS-1:0] inv_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STEP_W-1:0]   step_idx;

  logic [CHANNELS-1:0] bad_known;
  logic [CHANNELS-1:0] bad_x;
  logic [BC_W-1:0]     bad_cnt;
  logic [SUM_W-1:0]    err_sum;
  logic [CNT_W-1:0]    err_next;

  fanout_settle_compare #(
    .CHANNELS (CHANNELS),
    .CNT_BITS (BC_W)
  ) u_compare (
    .chan_in   (chan_in),
    .src       (src),
    .inv_q     (inv_q),
    .bad_known (bad_known),
    .bad_x     (bad_x),
    .bad_cnt   (bad_cnt)
  );

  // Sum in a wider width so the saturation compare cannot wrap.
  always_comb begin
    err_sum  = SUM_W'(err_count) + SUM_W'(bad_cnt);
    err_next = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      src       <= 1'b0;
      step_val  <= 1'b0;
      inv_q     <= '0;
      wait_cnt  <= '0;
      step_idx  <= '0;
      fail_mask <= '0;
      x_mask    <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            step_val  <= init_val;
            inv_q     <= invert_mask;
            step_idx  <= '0;
            fail_mask <= '0;
            x_mask    <= '0;
            err_count <= '0;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          src      <= step_val;
          wait_cnt <= '0;
          state    <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_CHECK: begin
          fail_mask <= fail_mask | bad_known;
          x_mask    <= x_mask | bad_x;
          err_count <= err_next;
          step_val  <= ~step_val;
          if (step_idx == STEP_LAST) begin
            state <= ST_DONE;
          end else begin
            step_idx <= step_idx + STEP_W'(1);
            state    <= ST_DRIVE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (fail_mask == '0) && (x_mask == '0);

endmodule

// File: tb/tb_fanout_settle_checker.sv
// tb_fanout_settle_checker
//   Directed runs against three instances: defaults, SETTLE_CYCLES=0, and
//   SETTLE_CYCLES=0 with a 2-bit error counter. Channel copies are modelled
//   in the bench as delayed (optionally inverted) versions of src.
module tb_fanout_settle_checker;

  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          init_val;
  logic [CH-1:0] invert_mask;

  logic [CH-1:0] chan_a;
  logic          src_a, busy_a, done_a, pass_a;
  logic [CH-1:0] fail_a, x_a;
  logic [15:0]   err_a;

  logic [CH-1:0] chan_b;
  logic          src_b, busy_b, done_b, pass_b;
  logic [CH-1:0] fail_b, x_b;
  logic [15:0]   err_b;

  logic          src_c, busy_c, done_c, pass_c;
  logic [CH-1:0] fail_c, x_c;
  logic [1:0]    err_c;

  logic d1 = 1'b0;
  logic b1 = 1'b0;
  logic b2 = 1'b0;
  logic stuck3 = 1'b0;
  logic x0 = 1'b0;
  logic probe;
  bit   four_state;

  int   n_vec = 0;
  int   n_err = 0;
  logic pass_seen;
  int   b_done_cyc;
  int   done_cyc;
  int   done_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= src_a;
    b1 <= src_b;
    b2 <= b1;
  end

  always_comb begin
    chan_a = {CH{d1}} ^ invert_mask;
    if (stuck3) chan_a[3] = 1'b0;
    if (x0) chan_a[0] = 1'bx;
    chan_b = {CH{b2}} ^ invert_mask;
  end

  fanout_settle_checker dut (
    .clk(clk), .rst(rst), .start(start), .init_val(init_val),
    .invert_mask(invert_mask), .chan_in(chan_a),
    .src(src_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_mask(fail_a), .x_mask(x_a), .err_count(err_a)
  );

  fanout_settle_checker #(.SETTLE_CYCLES(0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start), .init_val(init_val),
    .invert_mask(invert_mask), .chan_in(chan_b),
    .src(src_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_mask(fail_b), .x_mask(x_b), .err_count(err_b)
  );

  fanout_settle_checker #(.SETTLE_CYCLES(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .init_val(init_val),
    .invert_mask(invert_mask), .chan_in(chan_b),
    .src(src_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_mask(fail_c), .x_mask(x_c), .err_count(err_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run, 30 cycles. Cycle k is observed at the negedge after the k-th
  // posedge following the start request, so done is expected at k=17.
  task automatic run_once(input logic iv, input logic [CH-1:0] mask,
                          input bit ghosts, input int rst_at);
    logic e;
    init_val    = iv;
    invert_mask = mask;
    done_cyc    = 0;
    done_cnt    = 0;
    b_done_cyc  = 0;
    pass_seen   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = ghosts && (cyc == 4 || cyc == 17);
      if (rst_at != 0 && cyc == rst_at) begin
        chk("pre_rst_fail", 64'(fail_a), 64'h08);
        chk("pre_rst_src", 64'(src_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_src", 64'(src_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_fail", 64'(fail_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
      end
      if (rst_at != 0 && cyc == rst_at + 2) rst = 1'b0;
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc  = cyc;
          pass_seen = pass_a;
        end
      end
      if (done_b === 1'b1 && b_done_cyc == 0) b_done_cyc = cyc;
      if (rst_at == 0) begin
        if (cyc >= 2 && cyc <= 14 && ((cyc - 2) % 4) == 0) begin
          e = iv ^ (((cyc - 2) / 4) % 2 != 0);
          chk("src_seq", 64'(src_a), 64'(e));
        end
        if (cyc == 1 || cyc == 16) chk("busy_high", 64'(busy_a), 64'd1);
        if (cyc == 17) chk("busy_fall", 64'(busy_a), 64'd0);
      end
    end
  endtask

  initial begin
    probe      = 1'bx;
    four_state = $isunknown(probe);
    rst = 1'b1; start = 1'b0; init_val = 1'b0; invert_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_val_src", 64'(src_a), 64'd0);
    chk("rst_val_busy", 64'(busy_a), 64'd0);
    chk("rst_val_done", 64'(done_a), 64'd0);
    chk("rst_val_pass", 64'(pass_a), 64'd0);
    chk("rst_val_masks", {48'd0, fail_a, x_a}, 64'd0);
    chk("rst_val_err", 64'(err_a), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean run, init 1; the SETTLE_CYCLES=0 instances see stale copies.
    run_once(1'b1, 8'hAA, 1'b0, 0);
    chk("r1_done_cyc", 64'(done_cyc), 64'd17);
    chk("r1_pass", 64'(pass_seen), 64'd1);
    chk("r1_masks", {48'd0, fail_a, x_a}, 64'd0);
    chk("r1_err", 64'(err_a), 64'd0);
    chk("s0_done_cyc", 64'(b_done_cyc), 64'd9);
    chk("s0_fail", 64'(fail_b), 64'hFF);
    chk("s0_err", 64'(err_b), 64'd32);
    chk("sat_fail", 64'(fail_c), 64'hFF);
    chk("sat_err", 64'(err_c), 64'd3);

    // Clean run, init 0: src sequence 0,1,0,1.
    run_once(1'b0, 8'hAA, 1'b0, 0);
    chk("r2_done_cyc", 64'(done_cyc), 64'd17);
    chk("r2_pass", 64'(pass_seen), 64'd1);
    chk("r2_err", 64'(err_a), 64'd0);

    // Channel 3 stuck at 0 while expected 1,0,1,0.
    stuck3 = 1'b1;
    run_once(1'b0, 8'hAA, 1'b0, 0);
    stuck3 = 1'b0;
    chk("stuck_pass", 64'(pass_seen), 64'd0);
    chk("stuck_fail", 64'(fail_a), 64'h08);
    chk("stuck_x", 64'(x_a), 64'h00);
    chk("stuck_err", 64'(err_a), 64'd2);

    // Channel 0 unknown on every step (only meaningful on a 4-state simulator).
    if (four_state) begin
      x0 = 1'b1;
      run_once(1'b0, 8'hAA, 1'b0, 0);
      x0 = 1'b0;
      chk("x_pass", 64'(pass_seen), 64'd0);
      chk("x_mask", 64'(x_a), 64'h01);
      chk("x_fail", 64'(fail_a), 64'h00);
      chk("x_err", 64'(err_a), 64'd4);
    end else begin
      $display("note: 2-state simulator, X-channel run skipped");
    end

    // Start pulses while busy and during done are ignored.
    run_once(1'b0, 8'hAA, 1'b1, 0);
    chk("ghost_done_cnt", 64'(done_cnt), 64'd1);
    chk("ghost_done_cyc", 64'(done_cyc), 64'd17);
    chk("ghost_pass", 64'(pass_seen), 64'd1);
    chk("ghost_err", 64'(err_a), 64'd0);
    chk("ghost_idle", 64'(busy_a), 64'd0);

    // Reset mid-run, then a clean run.
    stuck3 = 1'b1;
    run_once(1'b0, 8'hAA, 1'b0, 9);
    stuck3 = 1'b0;
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_idle_busy", 64'(busy_a), 64'd0);
    run_once(1'b0, 8'hAA, 1'b0, 0);
    chk("post_rst_done_cyc", 64'(done_cyc), 64'd17);
    chk("post_rst_pass", 64'(pass_seen), 64'd1);
    chk("post_rst_masks", {48'd0, fail_a, x_a}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
